// File: rtl/alsu_arbiter_if.sv
// Requester, ALSU and response signals of the two-port ALSU arbiter.
// The master modport is the arbiter itself; slave is the surrounding system.
interface alsu_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [15:0] req0_cmd;
  logic [15:0] req1_cmd;
  logic [15:0] alsu_cmd;
  logic [5:0]  alsu_out;
  logic        resp_valid;
  logic        resp_ready;
  logic [5:0]  resp_data;
  logic        resp_id;
  logic        resp_err;
  logic        busy;
  logic [7:0]  err_cnt;

  modport master (
    input  req0_valid, req1_valid, req0_cmd, req1_cmd, alsu_out, resp_ready,
    output req0_ready, req1_ready, alsu_cmd, resp_valid, resp_data, resp_id,
           resp_err, busy, err_cnt
  );

  modport slave (
    output req0_valid, req1_valid, req0_cmd, req1_cmd, alsu_out, resp_ready,
    input  req0_ready, req1_ready, alsu_cmd, resp_valid, resp_data, resp_id,
           resp_err, busy, err_cnt
  );
endinterface

// File: rtl/alsu_arbiter.sv
// Two-requester round-robin arbiter in front of a registered ALSU.
// Command word: {cin,serial_in,direction,red_op_A,red_op_B,bypass_A,bypass_B,
// opcode[2:0],A[2:0],B[2:0]}. Illegal commands are answered directly with an
// error response and never reach the ALSU, so its shift/rotate history survives.
module alsu_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  alsu_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ptr;
  logic [15:0] r_alsu_cmd;
  logic [5:0]  r_resp_data;
  logic        r_resp_id;
  logic        r_resp_err;
  logic [7:0]  r_err_cnt;
  logic [3:0]  r_lat_cnt;

  logic        w_grant;
  logic        w_accept;
  logic        w_illegal;
  logic        w_last_wait;
  logic [15:0] w_cmd;
  logic [2:0]  w_opcode;

  // Grant selection, command mux and legality decode of the granted command
  always_comb begin
    w_grant   = 1'b0;
    w_cmd     = '0;
    w_opcode  = '0;
    w_illegal = 1'b0;
    w_accept  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant = r_ptr;
    end else begin
      w_grant = bus.req1_valid;
    end
    w_cmd     = w_grant ? bus.req1_cmd : bus.req0_cmd;
    w_opcode  = w_cmd[8:6];
    w_illegal = ((w_opcode == 3'b110 || w_opcode == 3'b111) && !(w_cmd[10] && w_cmd[9])) ||
                ((w_cmd[12] || w_cmd[11]) && !(w_opcode == 3'b000 || w_opcode == 3'b001));
    w_accept  = rst_n && (r_state == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
  end

  assign w_last_wait = (r_lat_cnt == LAT_LAST);

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt    = r_state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.busy       = 1'b0;
    bus.resp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.req0_ready = w_accept && !w_grant;
        bus.req1_ready = w_accept && w_grant;
        if (w_accept) begin
          w_state_nxt = w_illegal ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus.busy    = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        bus.busy = 1'b1;
        if (w_last_wait) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.busy       = 1'b1;
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accept bookkeeping: pointer, owner id, ALSU command and error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= 1'b0;
      r_resp_id  <= 1'b0;
      r_alsu_cmd <= '0;
      r_err_cnt  <= '0;
    end else if (w_accept) begin
      r_ptr     <= ~w_grant;
      r_resp_id <= w_grant;
      if (w_illegal) begin
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end else begin
        r_alsu_cmd <= w_cmd;
      end
    end
  end

  // Latency counter: cleared in ISSUE, advanced through WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_cnt <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_lat_cnt <= '0;
    end else if (r_state == ST_WAIT && !w_last_wait) begin
      r_lat_cnt <= r_lat_cnt + 4'd1;
    end
  end

  // Response payload: error response on illegal accept, ALSU sample at end of WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_resp_data <= '0;
      r_resp_err  <= 1'b1;
    end else if (r_state == ST_WAIT && w_last_wait) begin
      r_resp_data <= bus.alsu_out;
      r_resp_err  <= 1'b0;
    end
  end

  assign bus.alsu_cmd  = r_alsu_cmd;
  assign bus.resp_data = r_resp_data;
  assign bus.resp_id   = r_resp_id;
  assign bus.resp_err  = r_resp_err;
  assign bus.err_cnt   = r_err_cnt;

endmodule
